ecall_io_arbiter: RTL and testbench

//  Shares the board I/O resource (8 switches, confirm button, 32-bit segment data) between two

---
 rtl/ecall_io_arbiter.sv | 126 ++++++++++++
 tb/tb_ecall_io_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ecall_io_arbiter.sv
// Round-robin arbiter sharing board I/O (switches, confirm button, segment data) between the
// core ecall unit (port 0) and the debug monitor (port 1); runs print-int / read-int / exit.
//
// state | meaning
// IDLE  | no service active, arbitrate pending requests
// WAIT  | service granted, waiting for a debounced confirm press
// DONE  | completion pulse to the owner, one cycle
module ecall_io_arbiter #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [31:0] code0,
  input  logic [31:0] arg0,
  input  logic [31:0] code1,
  input  logic [31:0] arg1,
  input  logic [7:0]  switches,
  input  logic        button,
  output logic [1:0]  done,
  output logic [1:0]  wr,
  output logic [31:0] result,
  output logic [31:0] seg_data,
  output logic        busy,
  output logic        owner,
  output logic        halted
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_PRE = CW'(DEB_CYCLES - 1);

  localparam logic [31:0] C_PRINT = 32'd1;
  localparam logic [31:0] C_READ  = 32'd5;
  localparam logic [31:0] C_EXIT  = 32'd10;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state;
  logic [1:0]    sync_ff;
  logic [CW-1:0] deb_cnt;
  logic          btn_pulse;
  logic [31:0]   code_q;
  logic          gnt;
  logic [31:0]   code_sel;
  logic [31:0]   arg_sel;

  // Registered pulse lands in the same cycle the counter reaches DEB_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff   <= 2'b00;
      deb_cnt   <= '0;
      btn_pulse <= 1'b0;
    end else begin
      sync_ff   <= {sync_ff[0], button};
      btn_pulse <= sync_ff[1] && (deb_cnt == DEB_PRE);
      if (!sync_ff[1])
        deb_cnt <= '0;
      else if (deb_cnt != DEB_MAX)
        deb_cnt <= deb_cnt + 1'b1;
    end
  end

  always_comb begin
    gnt = req[1];
    if (req == 2'b11)
      gnt = ~owner;
    code_sel = gnt ? code1 : code0;
    arg_sel  = gnt ? arg1  : arg0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 2'b00;
      wr       <= 2'b00;
      result   <= '0;
      seg_data <= '0;
      busy     <= 1'b0;
      owner    <= 1'b1;
      halted   <= 1'b0;
      code_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!halted && req != 2'b00) begin
            owner  <= gnt;
            code_q <= code_sel;
            busy   <= 1'b1;
            if (code_sel == C_PRINT) begin
              seg_data <= arg_sel;
              state    <= WAIT;
            end else if (code_sel == C_READ) begin
              seg_data <= '0;
              state    <= WAIT;
            end else begin
              // Immediate codes complete in the grant cycle itself.
              done   <= gnt ? 2'b10 : 2'b01;
              wr     <= 2'b00;
              result <= '0;
              state  <= DONE;
              if (code_sel == C_EXIT)
                halted <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (btn_pulse) begin
            done[owner] <= 1'b1;
            wr[owner]   <= (code_q == C_READ);
            result      <= (code_q == C_READ) ? {24'b0, switches} : 32'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          done  <= 2'b00;
          wr    <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecall_io_arbiter.sv
// Randomized bench for ecall_io_arbiter against a transaction-level model of arbitration,
// display value, service result and halt behaviour.
module tb_ecall_io_arbiter;
  localparam int DEB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [31:0] code0, arg0, code1, arg1;
  logic [7:0]  switches;
  logic        button;
  logic [1:0]  done, wr;
  logic [31:0] result, seg_data;
  logic        busy, owner, halted;

  int total = 0;
  int bad = 0;

  // model: last granted requester, displayed value, halt flag
  logic        m_owner;
  logic [31:0] m_seg;
  logic        m_halted;

  logic [1:0]  rq_r;
  int          n_r;

  ecall_io_arbiter #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .req(req),
    .code0(code0), .arg0(arg0), .code1(code1), .arg1(arg1),
    .switches(switches), .button(button),
    .done(done), .wr(wr), .result(result), .seg_data(seg_data),
    .busy(busy), .owner(owner), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_done"},   32'(done),   32'd0);
    chk({tag, "_wr"},     32'(wr),     32'd0);
    chk({tag, "_result"}, result,      32'd0);
    chk({tag, "_seg"},    seg_data,    32'd0);
    chk({tag, "_busy"},   32'(busy),   32'd0);
    chk({tag, "_owner"},  32'(owner),  32'd1);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
  endtask

  function automatic logic [31:0] pick_code();
    case ($urandom_range(0, 3))
      0:       return 32'd1;
      1:       return 32'd5;
      2:       return 32'd4;
      default: return 32'd11 + 32'($urandom_range(0, 100));
    endcase
  endfunction

  // Entered and left at a negedge while the arbiter is idle.
  task automatic service(input logic [1:0] rq, input logic [31:0] fcode, input bit use_f);
    logic        w;
    logic [31:0] c, a, exp_res;
    logic [1:0]  exp_done, exp_wr;
    int          hold, n_done;
    bit          seen;
    w = (rq == 2'b11) ? ~m_owner : rq[1];
    code0 = pick_code(); code1 = pick_code();
    arg0 = $urandom; arg1 = $urandom;
    if (use_f) begin
      if (w) code1 = fcode; else code0 = fcode;
    end
    c = w ? code1 : code0;
    a = w ? arg1 : arg0;
    switches = 8'($urandom);
    req = rq;
    @(negedge clk);
    m_owner = w;
    if (c == 32'd1) m_seg = a;
    else if (c == 32'd5) m_seg = 32'd0;
    exp_done = w ? 2'b10 : 2'b01;
    chk("grant_busy",  32'(busy),  32'd1);
    chk("grant_owner", 32'(owner), 32'(m_owner));
    chk("grant_seg",   seg_data,   m_seg);
    if (c != 32'd1 && c != 32'd5) begin
      if (c == 32'd10) m_halted = 1'b1;
      chk("imm_done",   32'(done),   32'(exp_done));
      chk("imm_wr",     32'(wr),     32'd0);
      chk("imm_result", result,      32'd0);
      chk("imm_halted", 32'(halted), 32'(m_halted));
      req[w] = 1'b0;
      @(negedge clk);
      chk("imm_after_busy", 32'(busy), 32'd0);
      chk("imm_after_done", 32'(done), 32'd0);
      return;
    end
    chk("wait_nodone", 32'(done), 32'd0);
    n_done = 0;
    repeat (2) begin
      hold = $urandom_range(1, DEB - 2);
      for (int i = 0; i < hold + 4; i++) begin
        button = (i < hold);
        @(negedge clk);
        if (done != 2'b00) n_done++;
      end
    end
    chk("bounce_nodone", 32'(n_done), 32'd0);
    exp_res = (c == 32'd5) ? {24'b0, switches} : 32'd0;
    exp_wr  = (c == 32'd5) ? exp_done : 2'b00;
    hold = $urandom_range(DEB + 1, 3 * DEB);
    seen = 1'b0;
    for (int i = 0; i < 4 * DEB + 20 && !seen; i++) begin
      button = (i < hold);
      @(negedge clk);
      if (done != 2'b00) seen = 1'b1;
    end
    chk("press_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("press_done",   32'(done),   32'(exp_done));
      chk("press_wr",     32'(wr),     32'(exp_wr));
      chk("press_result", result,      exp_res);
      chk("press_seg",    seg_data,    m_seg);
      chk("press_halted", 32'(halted), 32'(m_halted));
    end
    req[w] = 1'b0;
    if (req != 2'b00) button = 1'b0;
    @(negedge clk);
    chk("after_busy", 32'(busy), 32'd0);
    chk("after_done", 32'(done), 32'd0);
    if (req == 2'b00) begin
      n_done = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (done != 2'b00 || busy) n_done++;
      end
      button = 1'b0;
      repeat (4) @(negedge clk);
      chk("hold_single", 32'(n_done), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; button = 1'b0; switches = 8'h00;
    code0 = '0; arg0 = '0; code1 = '0; arg1 = '0;
    m_owner = 1'b1; m_seg = '0; m_halted = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;
    @(negedge clk);

    service(2'b01, 32'd1, 1'b1);
    service(2'b10, 32'd5, 1'b1);

    repeat (3) begin
      service(2'b11, 32'd0, 1'b0);
      service(req, 32'd0, 1'b0);
    end

    repeat (20) begin
      rq_r = 2'($urandom_range(1, 3));
      service(rq_r, 32'd0, 1'b0);
      if (req != 2'b00) service(req, 32'd0, 1'b0);
    end

    // Reset while a read-int service is waiting for the button.
    code0 = 32'd5; arg0 = $urandom; req = 2'b01;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    m_owner = 1'b1; m_seg = '0; m_halted = 1'b0;
    n_r = 0;
    repeat (5) begin
      @(negedge clk);
      if (done != 2'b00 || busy) n_r++;
    end
    chk("midrst_quiet", 32'(n_r), 32'd0);
    service(2'b01, 32'd1, 1'b1);

    service(2'b01, 32'd10, 1'b1);
    code1 = 32'd1; arg1 = $urandom; req = 2'b10;
    n_r = 0;
    repeat (15) begin
      @(negedge clk);
      if (done != 2'b00 || busy) n_r++;
    end
    chk("halt_blocked", 32'(n_r), 32'd0);
    chk("halt_sticky", 32'(halted), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
